multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 The block SHALL have parameter TRAP_ON_ILLEGAL, default 1: 1 = halt in TRAP on an unknown opcode, 0 = treat it as a NOP.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port instruction, input, 6 bits: opcode field of the instruction register, sampled in DECODE.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory completion handshake.
REQ-007 The block SHALL have these 1-bit outputs: PCWrite, PCWriteCond, BNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, LUI, illegal.
REQ-008 The block SHALL have these 2-bit outputs: ALUSrcB, ALUOp, PCSource.
REQ-009 The block SHALL have output state, 4 bits: current FSM state encoding, for debug.
REQ-010 The block SHALL have output retired, CNT_W bits: count of completed instructions.

Function
REQ-011 The block SHALL be a Moore FSM; every control output SHALL be a function of state only, except that IRWrite and PCWrite in FETCH are gated by mem_ready.
REQ-012 Opcodes SHALL be: R-type 000000, BEQ 000100, BNE 000011, SW 101011, LW 100011, ADDI 001000, J 000010, LUI 001111.
REQ-013 ALUOp encodings SHALL be: 00 = R-type/funct, 01 = subtract, 10 = add, 11 = pass/other.
REQ-014 Any output not listed for a state SHALL be 0 in that state.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=10, PCSource=00, IRWrite=PCWrite=mem_ready; holds while mem_ready=0, then goes to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=10; next state is MEM_ADDR for LW/SW, R_EXEC for R-type, I_EXEC for ADDI/LUI, BRANCH for BEQ/BNE, JUMP for J, otherwise TRAP (TRAP_ON_ILLEGAL=1) or FETCH (TRAP_ON_ILLEGAL=0).
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=10; next state is MEM_RD for LW, MEM_WR for SW.
REQ-018 MEM_RD: MemRead=1, IorD=1; holds until mem_ready=1, then goes to MEM_WB.
REQ-019 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; then goes to FETCH.
REQ-020 MEM_WR: MemWrite=1, IorD=1; holds until mem_ready=1, then goes to FETCH.
REQ-021 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00; then goes to R_WB.
REQ-022 R_WB: RegDst=1, RegWrite=1, ALUOp=00; then goes to FETCH.
REQ-023 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=10 for ADDI or 11 with LUI=1 for LUI; then goes to I_WB.
REQ-024 I_WB: RegWrite=1, RegDst=0, with ALUOp and LUI held from I_EXEC; then goes to FETCH.
REQ-025 I_EXEC and I_WB SHALL latch the opcode class in a register captured in DECODE, so that a change on instruction after DECODE has no effect.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1 for BEQ, BNE=1 for BNE; then goes to FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10, ALUOp=11; then goes to FETCH.
REQ-028 TRAP: illegal=1 and all other controls 0; the FSM stays in TRAP until reset.
REQ-029 retired SHALL increment by 1 on each exit to FETCH from MEM_WB, MEM_WR (with mem_ready=1), R_WB, I_WB, BRANCH or JUMP; it SHALL wrap modulo 2^CNT_W.
REQ-030 The illegal-as-NOP path (DECODE to FETCH) SHALL NOT increment retired.
REQ-031 mem_ready asserted in a state that does not wait on memory SHALL be ignored.
REQ-032 mem_ready held high continuously SHALL give minimum latencies: LW 5 cycles, SW 4, R/ADDI/LUI 4, BEQ/BNE/J 3.

Reset
REQ-033 reset=1 SHALL force, asynchronously and independent of clk, state=FETCH, retired=0, the latched opcode class cleared, and illegal=0.
REQ-034 While reset=1, FETCH's Moore outputs SHALL be driven, with IRWrite=PCWrite=0.
REQ-035 Reset asserted mid-instruction, including during a memory wait, SHALL abort that instruction with no RegWrite or MemWrite pulse and no retired increment.
REQ-036 After reset deasserts, the first rising edge of clk SHALL evaluate FETCH normally.

Verification
REQ-037 Scenario: reset released, mem_ready=1, LW (100011) -> state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; one RegWrite pulse with MemtoReg=1; retired=1.
REQ-038 Scenario: SW with mem_ready held low for 3 cycles in MEM_WR -> MemWrite=1 for 4 cycles; retired increments only on the cycle mem_ready=1.
REQ-039 Scenario: BNE (000011), then BEQ (000100) -> BRANCH drives ALUOp=01 and PCSource=01 for both; BNE=1 and PCWriteCond=0 for BNE; BNE=0 and PCWriteCond=1 for BEQ.
REQ-040 Scenario: LUI with instruction changed to 000000 during I_EXEC -> LUI=1 and ALUOp=11 through I_WB; RegDst=0.
REQ-041 Scenario: opcode 111111 -> with TRAP_ON_ILLEGAL=1, illegal=1 stuck until reset; with TRAP_ON_ILLEGAL=0, returns to FETCH with retired unchanged.
REQ-042 Scenario: CNT_W=2, six R-type instructions -> retired sequence 1, 2, 3, 0, 1, 2; reset asserted mid-R_EXEC -> retired=0 immediately and no RegWrite.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM that sequences datapath controls per opcode
// and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       instruction,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             LUI,
    output logic             illegal,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StIExec   = 4'd8,
        StIWb     = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StTrap    = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        ClsNone,
        ClsLw,
        ClsSw,
        ClsR,
        ClsAddi,
        ClsLui,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsIllegal
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, dec_cls;
    logic [CNT_W-1:0]  retired_q;
    logic              retire;

    always_comb begin
        case (instruction)
            6'b000000: dec_cls = ClsR;
            6'b000100: dec_cls = ClsBeq;
            6'b000011: dec_cls = ClsBne;
            6'b101011: dec_cls = ClsSw;
            6'b100011: dec_cls = ClsLw;
            6'b001000: dec_cls = ClsAddi;
            6'b000010: dec_cls = ClsJ;
            6'b001111: dec_cls = ClsLui;
            default:   dec_cls = ClsIllegal;
        endcase
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (dec_cls)
                    ClsLw, ClsSw:    state_d = StMemAddr;
                    ClsR:            state_d = StRExec;
                    ClsAddi, ClsLui: state_d = StIExec;
                    ClsBeq, ClsBne:  state_d = StBranch;
                    ClsJ:            state_d = StJump;
                    default:         state_d = (TRAP_ON_ILLEGAL != 0) ? StTrap : StFetch;
                endcase
            end
            StMemAddr: begin
                if (cls_q == ClsLw)      state_d = StMemRd;
                else if (cls_q == ClsSw) state_d = StMemWr;
                else                     state_d = StFetch;
            end
            StMemRd: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StRExec: state_d = StRWb;
            StIExec: state_d = StIWb;
            StMemWb, StRWb, StIWb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Opcode class is captured in DECODE so later states ignore the live instruction bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) cls_q <= dec_cls;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BNE         = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        LUI         = 1'b0;
        illegal     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                // Reset must not let a pending fetch handshake write IR or PC.
                IRWrite = mem_ready & ~reset;
                PCWrite = mem_ready & ~reset;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                ALUOp   = 2'b10;
            end
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StRExec: begin
                ALUSrcA = 1'b1;
            end
            StRWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StIExec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (cls_q == ClsLui) ? 2'b11 : 2'b10;
                LUI     = (cls_q == ClsLui);
            end
            StIWb: begin
                RegWrite = 1'b1;
                ALUOp    = (cls_q == ClsLui) ? 2'b11 : 2'b10;
                LUI      = (cls_q == ClsLui);
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = (cls_q == ClsBeq);
                BNE         = (cls_q == ClsBne);
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                ALUOp    = 2'b11;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
